if_pc_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage pipeline.
- Owns the program counter and drives the instruction-memory address.
- Produces the PC and PC+4 values that the IF/ID state register captures.
- Arbitrates next-PC sources (exception, interrupt, EX-stage branch, ID-stage jump, stall, sequential) and raises flush requests for the IF/ID and ID/EX registers. Supervisor mode is PC[31]=1.

---
 rtl/if_pc_stage.sv | 130 +++++++++++++
 tb/tb_if_pc_stage.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/if_pc_stage.sv
// if_pc_stage: instruction-fetch program counter and next-PC arbitration.
// Owns the fetch PC and the pending-interrupt latch. Picks the next PC from
// exception, EX branch, interrupt, ID jump, stall or sequential sources, and
// raises the IF/ID and ID/EX flush requests in the same cycle as the redirect.
// Supervisor mode is pc[31]=1. Only jr and reset/vectors may change that bit.
// Optional feature: define IF_FETCH_CNT_EN to add fetch_count, which counts
// sequential (pc_plus4) loads.
module if_pc_stage #(
    parameter logic [31:0] RESET_VEC = 32'h80000000,
    parameter logic [31:0] IRQ_VEC   = 32'h80000004,
    parameter logic [31:0] EXC_VEC   = 32'h80000008
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        exc,
    input  logic        irq,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jmp_valid,
    input  logic        jmp_is_jr,
    input  logic [31:0] jmp_target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        flush_ifid,
    output logic        flush_idex,
    output logic        irq_ack,
    output logic [31:0] epc
`ifdef IF_FETCH_CNT_EN
    ,
    output logic [31:0] fetch_count
`endif
);

    logic [31:0] pc_q, pc_d;
    logic        irq_pending_q, irq_pending_d;
    logic        irq_take;
`ifdef IF_FETCH_CNT_EN
    logic [31:0] fetch_count_q, fetch_count_d;
    logic        seq_adv;
`endif

    assign pc = pc_q;

    // Increment only the low 31 bits so the supervisor bit is never changed by
    // sequential fetch; the low bits wrap modulo 2^31.
    assign pc_plus4 = {pc_q[31], pc_q[30:0] + 31'd4};

    // An interrupt is taken only in user mode and only in a cycle that has no
    // older redirect, no live jump and no stall.
    assign irq_take = irq_pending_q & ~pc_q[31] & ~exc & ~br_taken
                    & ~(jmp_valid & ~stall) & ~stall;

    // Next-PC arbitration and redirect side effects; reset masks all outputs.
    always_comb begin
        pc_d       = pc_plus4;
        flush_ifid = 1'b0;
        flush_idex = 1'b0;
        irq_ack    = 1'b0;
        epc        = 32'h0;
`ifdef IF_FETCH_CNT_EN
        seq_adv    = 1'b0;
`endif
        if (reset) begin
            pc_d = RESET_VEC;
        end else if (exc) begin
            pc_d       = EXC_VEC;
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
            epc        = pc_q;
        end else if (br_taken) begin
            // The branch is older than any stalled instruction, so it wins.
            pc_d       = {pc_q[31], br_target[30:0]};
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
        end else if (irq_take) begin
            pc_d       = IRQ_VEC;
            flush_ifid = 1'b1;
            irq_ack    = 1'b1;
            epc        = pc_q;
        end else if (jmp_valid && !stall) begin
            // Only jr may leave supervisor mode; j/jal keep the current bit.
            pc_d       = jmp_is_jr ? jmp_target : {pc_q[31], jmp_target[30:0]};
            flush_ifid = 1'b1;
        end else if (stall) begin
            pc_d = pc_q;
        end else begin
            pc_d = pc_plus4;
`ifdef IF_FETCH_CNT_EN
            seq_adv = 1'b1;
`endif
        end
    end

    // Pending latch: set by any irq level, cleared by the ack unless irq is
    // still asserted in the ack cycle.
    always_comb begin
        irq_pending_d = (irq_pending_q & ~irq_ack) | irq;
    end

    // PC and interrupt-pending registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RESET_VEC;
            irq_pending_q <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            irq_pending_q <= irq_pending_d;
        end
    end

`ifdef IF_FETCH_CNT_EN
    assign fetch_count = fetch_count_q;

    // Count sequential fetches only; wraps naturally at 32 bits.
    always_comb begin
        fetch_count_d = fetch_count_q + {31'h0, seq_adv};
    end

    // Fetch counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count_q <= 32'h0;
        end else begin
            fetch_count_q <= fetch_count_d;
        end
    end
`endif

endmodule

// File: tb/tb_if_pc_stage.sv
// tb_if_pc_stage: directed-vector bench for if_pc_stage. The driver applies
// one cycle of inputs on the falling edge and queues the outputs expected in
// that cycle; the monitor compares shortly afterwards, before the rising edge.
module tb_if_pc_stage;

    localparam int W = 99; // {pc, pc_plus4, flush_ifid, flush_idex, irq_ack, epc}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        stall = 1'b0, exc = 1'b0, irq = 1'b0, br_taken = 1'b0;
    logic        jmp_valid = 1'b0, jmp_is_jr = 1'b0;
    logic [31:0] br_target = 32'h0, jmp_target = 32'h0;
    logic [31:0] pc, pc_plus4, epc;
    logic        flush_ifid, flush_idex, irq_ack;
`ifdef IF_FETCH_CNT_EN
    logic [31:0] fetch_count;
`endif

    if_pc_stage dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .exc       (exc),
        .irq       (irq),
        .br_taken  (br_taken),
        .br_target (br_target),
        .jmp_valid (jmp_valid),
        .jmp_is_jr (jmp_is_jr),
        .jmp_target(jmp_target),
        .pc        (pc),
        .pc_plus4  (pc_plus4),
        .flush_ifid(flush_ifid),
        .flush_idex(flush_idex),
        .irq_ack   (irq_ack),
        .epc       (epc)
`ifdef IF_FETCH_CNT_EN
        ,
        .fetch_count(fetch_count)
`endif
    );

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    logic [31:0]  cnt_q[$];
    string        name_q[$];
    logic [31:0]  exp_cnt = 32'h0;
    int           checks = 0;
    int           passed = 0;
    logic         chk_tick = 1'b0;

    function automatic logic [31:0] plus4(input logic [31:0] p);
        return {p[31], p[30:0] + 31'd4};
    endfunction

    // ---------------- driver ----------------
    // kind: 0 idle, 1 stall, 2 j, 3 jr; seq marks a pc_plus4 load this cycle.
    task automatic step(input string nm, input logic rst, input int kind,
                        input logic e, input logic ir, input logic br,
                        input logic [31:0] tgt,
                        input logic [31:0] x_pc, input logic x_fi,
                        input logic x_fe, input logic x_ack,
                        input logic [31:0] x_epc, input logic seq);
        @(negedge clk);
        reset      = rst;
        stall      = (kind == 1);
        jmp_valid  = (kind == 2) || (kind == 3) || (kind == 1 && tgt != 0 && !br);
        jmp_is_jr  = (kind == 3);
        jmp_target = tgt;
        br_taken   = br;
        br_target  = tgt;
        exc        = e;
        irq        = ir;
        exp_q.push_back({x_pc, plus4(x_pc), x_fi, x_fe, x_ack, x_epc});
        cnt_q.push_back(exp_cnt);
        name_q.push_back(nm);
        if (rst)      exp_cnt = 32'h0;
        else if (seq) exp_cnt = exp_cnt + 32'd1;
        chk_tick = ~chk_tick;
    endtask

    // ---------------- monitor ----------------
    always @(chk_tick) begin
        logic [W-1:0] act, x;
        logic [31:0]  xc;
        string        nm;
        #1;
        act = {pc, pc_plus4, flush_ifid, flush_idex, irq_ack, epc};
        if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL no_expectation: output presented with empty queue");
        end else begin
            x  = exp_q.pop_front();
            xc = cnt_q.pop_front();
            nm = name_q.pop_front();
            checks++;
            if (act === x) passed++;
            else $display("FAIL %s: got pc=%h p4=%h fi=%b fe=%b ack=%b epc=%h want pc=%h p4=%h fi=%b fe=%b ack=%b epc=%h",
                          nm, act[98:67], act[66:35], act[34], act[33], act[32], act[31:0],
                          x[98:67], x[66:35], x[34], x[33], x[32], x[31:0]);
`ifdef IF_FETCH_CNT_EN
            checks++;
            if (fetch_count === xc) passed++;
            else $display("FAIL %s_fetch_count: got %h want %h", nm, fetch_count, xc);
`else
            if (xc === 32'hx) $display("note: count unknown");
`endif
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        repeat (2) @(posedge clk);
        // Reset held with redirect inputs active: outputs must stay quiet.
        step("reset",      1, 0, 1, 1, 1, 32'h00400000, 32'h80000000, 0, 0, 0, 32'h0, 0);
        step("seq0",       0, 0, 0, 0, 0, 32'h0,        32'h80000000, 0, 0, 0, 32'h0, 1);
        step("seq1",       0, 0, 0, 0, 0, 32'h0,        32'h80000004, 0, 0, 0, 32'h0, 1);
        step("seq2",       0, 0, 0, 0, 0, 32'h0,        32'h80000008, 0, 0, 0, 32'h0, 1);
        step("jr_user",    0, 3, 0, 0, 0, 32'h00400010, 32'h8000000C, 1, 0, 0, 32'h0, 0);
        step("stall_jmp0", 0, 1, 0, 0, 0, 32'h00400100, 32'h00400010, 0, 0, 0, 32'h0, 0);
        step("stall_jmp1", 0, 1, 0, 0, 0, 32'h00400100, 32'h00400010, 0, 0, 0, 32'h0, 0);
        step("jmp_after",  0, 2, 0, 0, 0, 32'h00400100, 32'h00400010, 1, 0, 0, 32'h0, 0);
        step("jr_420",     0, 3, 0, 0, 0, 32'h00400020, 32'h00400100, 1, 0, 0, 32'h0, 0);
        step("br_stall",   0, 1, 0, 0, 1, 32'h00400040, 32'h00400020, 1, 1, 0, 32'h0, 0);
        step("jr_super",   0, 3, 0, 0, 0, 32'h80000100, 32'h00400040, 1, 0, 0, 32'h0, 0);
        step("irq_masked", 0, 0, 0, 1, 0, 32'h0,        32'h80000100, 0, 0, 0, 32'h0, 1);
        step("irq_pend_s", 0, 0, 0, 0, 0, 32'h0,        32'h80000104, 0, 0, 0, 32'h0, 1);
        step("jr_user2",   0, 3, 0, 0, 0, 32'h00400000, 32'h80000108, 1, 0, 0, 32'h0, 0);
        step("irq_stall",  0, 1, 0, 0, 0, 32'h0,        32'h00400000, 0, 0, 0, 32'h0, 0);
        step("irq_ack",    0, 0, 0, 0, 0, 32'h0,        32'h00400000, 1, 0, 1, 32'h00400000, 0);
        step("irq_vec",    0, 0, 0, 0, 0, 32'h0,        32'h80000004, 0, 0, 0, 32'h0, 1);
        step("jr_irqset",  0, 3, 0, 1, 0, 32'h00400200, 32'h80000008, 1, 0, 0, 32'h0, 0);
        step("exc_prio",   0, 0, 1, 0, 1, 32'h00400400, 32'h00400200, 1, 1, 0, 32'h00400200, 0);
        step("jr_after_e", 0, 3, 0, 0, 0, 32'h00400300, 32'h80000008, 1, 0, 0, 32'h0, 0);
        step("ack_kept",   0, 0, 0, 0, 0, 32'h0,        32'h00400300, 1, 0, 1, 32'h00400300, 0);
        step("jr_irq2",    0, 3, 0, 1, 0, 32'h00400400, 32'h80000004, 1, 0, 0, 32'h0, 0);
        step("ack_irq_hi", 0, 0, 0, 1, 0, 32'h0,        32'h00400400, 1, 0, 1, 32'h00400400, 0);
        step("jr_irq3",    0, 3, 0, 0, 0, 32'h00400500, 32'h80000004, 1, 0, 0, 32'h0, 0);
        step("ack_again",  0, 0, 0, 0, 0, 32'h0,        32'h00400500, 1, 0, 1, 32'h00400500, 0);
        step("jr_wrap",    0, 3, 0, 0, 0, 32'h7FFFFFFC, 32'h80000004, 1, 0, 0, 32'h0, 0);
        step("wrap",       0, 0, 0, 0, 0, 32'h0,        32'h7FFFFFFC, 0, 0, 0, 32'h0, 1);
        step("wrap_zero",  0, 0, 0, 0, 0, 32'h0,        32'h00000000, 0, 0, 0, 32'h0, 1);
        step("jr_sup2",    0, 3, 0, 0, 0, 32'h80000010, 32'h00000004, 1, 0, 0, 32'h0, 0);
        step("j_keep_sup", 0, 2, 0, 0, 0, 32'h00001000, 32'h80000010, 1, 0, 0, 32'h0, 0);
        step("br_keep_sup",0, 0, 0, 0, 1, 32'h00000050, 32'h80001000, 1, 1, 0, 32'h0, 0);
        step("irq_set_sup",0, 0, 0, 1, 0, 32'h0,        32'h80000050, 0, 0, 0, 32'h0, 1);
        step("reset_mid",  1, 0, 1, 0, 0, 32'h0,        32'h80000054, 0, 0, 0, 32'h0, 0);
        step("post_reset", 0, 0, 0, 0, 0, 32'h0,        32'h80000000, 0, 0, 0, 32'h0, 1);
        step("jr_user4",   0, 3, 0, 0, 0, 32'h00400600, 32'h80000004, 1, 0, 0, 32'h0, 0);
        step("no_pending", 0, 0, 0, 0, 0, 32'h0,        32'h00400600, 0, 0, 0, 32'h0, 1);
        step("final",      0, 0, 0, 0, 0, 32'h0,        32'h00400604, 0, 0, 0, 32'h0, 1);
        @(negedge clk);
        #3;
        if (exp_q.size() != 0) begin
            checks++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
